param_shift_register: RTL

Parametrised parallel-in/serial-out shift register, the successor to the fixed 8-bit operand register in the serial adder datapath. Adds configurable width and shift direction, a serial fill input, a parallel readback, and a bit counter with busy/done handshake. A serial adder controller can sequence operands without its own external counter. Two instances feed the full-adder cell; a third, driven through ser_in, collects the sum bits.

---
 rtl/param_shift_register_pkg.sv | 16 +
 rtl/param_shift_register_counter.sv | 38 +++
 rtl/param_shift_register.sv | 98 +++++++++
 3 files changed

// File: rtl/param_shift_register_pkg.sv
// Shared definitions for the serial-adder operand shift register and its controller:
// state encoding and the bit-counter width helper.
package param_shift_register_pkg;

    typedef logic [1:0] sr_state_t;

    localparam sr_state_t ST_IDLE  = 2'd0;
    localparam sr_state_t ST_SHIFT = 2'd1;
    localparam sr_state_t ST_DONE  = 2'd2;

    // Counter width able to represent 0..width inclusive.
    function automatic int unsigned cw_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/param_shift_register_counter.sv
// Saturating shift counter: counts enabled shifts since the last clear, flags the final shift.
module shift_bit_counter
    import param_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = cw_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != CW'(WIDTH))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/param_shift_register.sv
// Parallel-in/serial-out operand register with serial fill, parallel readback,
// and a busy/done handshake driven by an internal bit counter.
module param_shift_register
    import param_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1,
    localparam int unsigned CW = cw_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] sr_in,
    input  logic             ser_in,
    output logic             sr_out,
    output logic [WIDTH-1:0] par_out,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             done
);

    sr_state_t        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] shifted;
    logic             do_shift;
    logic             last;

    // A load wins over enable; shifts happen only inside an active sequence.
    assign do_shift = !load && (state_q == ST_SHIFT) && enable;

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (load),
        .inc   (do_shift),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_SHIFT;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_SHIFT: if (enable && last) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
    end

    always_comb begin
        if (LSB_FIRST) begin
            shifted = {ser_in, data_q[WIDTH-1:1]};
        end else begin
            shifted = {data_q[WIDTH-2:0], ser_in};
        end
    end

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = sr_in;
        end else if (do_shift) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign sr_out  = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
    assign par_out = data_q;

endmodule
